// File: rtl/write_back_pkg.sv
// Shared pipeline constants: default data width, register-index width and the
// hard-wired zero register index.
package write_back_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/write_back.sv
// Write-back stage: selects between load data and the ALU result and registers
// the register-file write port (enable, index, data) with one cycle of latency.
module write_back
    import write_back_pkg::*;
#(
    parameter int BW = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memtoreg,
    input  logic             readwrite,
    input  logic [BW-1:0]    in_data,
    input  logic [BW-1:0]    in_origenal,
    input  logic [REG_W-1:0] rd_in,
    output logic             return_readwrite,
    output logic [BW-1:0]    return_data,
    output logic [REG_W-1:0] rd_out
);

    // No handshake: every rising edge accepts one result and presents it on the
    // outputs until the next edge; consumers qualify data/index with
    // return_readwrite.
    logic [BW-1:0] wb_value;

    always_comb begin
        wb_value = memtoreg ? in_data : in_origenal;
    end

    // x0 is hard-wired to zero, so a write to it is never signalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            return_readwrite <= 1'b0;
            return_data      <= '0;
            rd_out           <= REG_ZERO;
        end else begin
            return_readwrite <= readwrite && (rd_in != REG_ZERO);
            return_data      <= wb_value;
            rd_out           <= rd_in;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: reset behaviour, mux select, x0 suppression,
// wide index driver and a back-to-back stream interrupted by an async reset.
`timescale 1ns/1ps
module tb_write_back;
    import write_back_pkg::*;

    localparam int BW = 32;

    logic          clk;
    logic          rst;
    logic          memtoreg;
    logic          readwrite;
    logic [BW-1:0] in_data;
    logic [BW-1:0] in_origenal;
    logic [31:0]   rd_wide;
    logic [4:0]    rd_in;
    logic          return_readwrite;
    logic [BW-1:0] return_data;
    logic [4:0]    rd_out;

    int n_checks;
    int n_pass;

    logic [BW-1:0] exp_q[$];
    logic [4:0]    exp_rd_q[$];
    logic          exp_rw_q[$];

    // Only the low five bits of a wider index driver reach the port.
    assign rd_in = rd_wide[4:0];

    write_back #(.BW(BW)) dut (
        .clk              (clk),
        .rst              (rst),
        .memtoreg         (memtoreg),
        .readwrite        (readwrite),
        .in_data          (in_data),
        .in_origenal      (in_origenal),
        .rd_in            (rd_in),
        .return_readwrite (return_readwrite),
        .return_data      (return_data),
        .rd_out           (rd_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic rw, input logic [4:0] rd,
                                 input logic [31:0] data);
        check({tag, ".rw"},   {31'd0, return_readwrite}, {31'd0, rw});
        check({tag, ".rd"},   {27'd0, rd_out},           {27'd0, rd});
        check({tag, ".data"}, return_data,               data);
    endtask

    // driver: apply inputs on the falling edge, sample 1ns after the rising edge
    task automatic drive(input logic m, input logic rw, input logic [31:0] d,
                         input logic [31:0] o, input logic [31:0] rdw);
        @(negedge clk);
        memtoreg    = m;
        readwrite   = rw;
        in_data     = d;
        in_origenal = o;
        rd_wide     = rdw;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic        m;
        logic        rw;
        logic [31:0] d;
        logic [31:0] o;
        logic [31:0] rdw;
        logic        exp_rw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"mem_sel", 1'b1, 1'b1, 32'hFFFF_DDDD, 32'hDDDD_FFFF, 32'h11,
                    1'b1, 5'h11, 32'hFFFF_DDDD};
        vecs[1] = '{"alu_sel", 1'b0, 1'b0, 32'hFFFF_DDDD, 32'hDDDD_FFFF, 32'h02,
                    1'b0, 5'h02, 32'hDDDD_FFFF};
        vecs[2] = '{"x0_sup",  1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 32'h00,
                    1'b0, 5'h00, 32'h1234_5678};
        vecs[3] = '{"wide_rd", 1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_5555, 32'h2222_2222,
                    1'b1, 5'h02, 32'h0000_5555};
        vecs[4] = '{"rd_max",  1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1F,
                    1'b1, 5'h1F, 32'h0000_0000};
        vecs[5] = '{"wide_x0", 1'b0, 1'b1, 32'h0BAD_F00D, 32'hCAFE_BEEF, 32'hFFFF_FFE0,
                    1'b0, 5'h00, 32'hCAFE_BEEF};
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset with non-zero inputs, checked before the first clock edge.
        rst         = 1'b1;
        memtoreg    = 1'b1;
        readwrite   = 1'b1;
        in_data     = 32'hFFFF_DDDD;
        in_origenal = 32'hDDDD_FFFF;
        rd_wide     = 32'h11;
        #2;
        check_outputs("reset_no_edge", 1'b0, 5'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_held", 1'b0, 5'h00, 32'h0);

        // Release on a falling edge: nothing appears until the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("post_release", 1'b0, 5'h00, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].m, vecs[i].rw, vecs[i].d, vecs[i].o, vecs[i].rdw);
            check_outputs(vecs[i].tag, vecs[i].exp_rw, vecs[i].exp_rd, vecs[i].exp_data);
        end

        // Back-to-back writes to x1..x6, with a reset pulse between edges after x3.
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] d;
            logic [31:0] o;
            logic        m;
            d = $urandom;
            o = $urandom;
            m = (k % 2) == 1;
            exp_q.push_back(m ? d : o);
            exp_rd_q.push_back(5'(k));
            exp_rw_q.push_back(1'b1);
            drive(m, 1'b1, d, o, 32'(k));
            check_outputs($sformatf("stream%0d", k), exp_rw_q.pop_front(),
                          exp_rd_q.pop_front(), exp_q.pop_front());
            if (k == 3) begin
                #1;
                rst = 1'b1;
                #1;
                check_outputs("midrun_rst", 1'b0, 5'h00, 32'h0);
                rst = 1'b0;
                #1;
                check_outputs("midrun_released", 1'b0, 5'h00, 32'h0);
            end
        end

        // Inputs held after the stream: outputs follow on the next edge.
        drive(1'b0, 1'b0, 32'h0, 32'h0000_0001, 32'h1F);
        check_outputs("final_idle", 1'b0, 5'h1F, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 The block SHALL have parameter BW, default 32, giving the data path width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port memtoreg, input, 1 bit: result select, 1 = memory load data, 0 = ALU/original result.
REQ-005 The block SHALL have port readwrite, input, 1 bit: register-file write request from the memory stage.
REQ-006 The block SHALL have port in_data, input, BW bits: data loaded from memory.
REQ-007 The block SHALL have port in_origenal, input, BW bits: ALU/original result passed through the memory stage.
REQ-008 The block SHALL have port rd_in, input, 5 bits: destination register index; only bits [4:0] of any wider driver are used.
REQ-009 The block SHALL have port return_readwrite, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port return_data, output, BW bits: register-file write data.
REQ-011 The block SHALL have port rd_out, output, 5 bits: register-file write index.

Function
REQ-012 The block SHALL select the write-back value as in_data when memtoreg=1, and as in_origenal when memtoreg=0.
REQ-013 The block SHALL register every output, so inputs sampled at rising edge N appear on the outputs immediately after edge N (latency 1 cycle, one result per cycle, no stalls, no handshake).
REQ-014 On each rising edge while rst=0, return_data SHALL be loaded with the selected value.
REQ-015 On each rising edge while rst=0, rd_out SHALL be loaded with rd_in[4:0].
REQ-016 On each rising edge while rst=0, return_readwrite SHALL be loaded with readwrite AND (rd_in[4:0] != 0), so that a write to register x0 is never signalled.
REQ-017 When return_readwrite=0, return_data and rd_out SHALL still reflect the registered values, and consumers SHALL ignore them.
REQ-018 The block SHALL contain no state other than the three output registers, and the outputs SHALL depend on no other history.
REQ-019 X-free operation: with defined inputs and rst applied once, the outputs SHALL never be X.

Reset
REQ-020 While rst=1, the block SHALL force return_readwrite=0, return_data=0 and rd_out=0 immediately, independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-022 After rst deasserts, the first valid output SHALL appear after the next rising edge.

Structure
REQ-023 BW's default and the register-index width (5) SHALL live in the shared pipeline package as constants, together with the constant REG_ZERO = 5'd0.
REQ-024 The block SHALL be implemented as one flat module with no sub-modules, the select being an inline 2:1 mux ahead of the output register.

Verification
REQ-025 Scenario (reset): rst=1 with inputs non-zero -> all outputs 0 without a clock edge.
REQ-026 Scenario (memory select): memtoreg=1, readwrite=1, in_data=0xFFFFDDDD, in_origenal=0xDDDDFFFF, rd_in=0x11 -> after the next edge, return_data=0xFFFFDDDD, rd_out=0x11, return_readwrite=1.
REQ-027 Scenario (ALU select): memtoreg=0, readwrite=0, same data, rd_in=0x02 -> after the next edge, return_data=0xDDDDFFFF, rd_out=0x02, return_readwrite=0.
REQ-028 Scenario (x0 suppression): memtoreg=1, readwrite=1, rd_in=0 -> return_readwrite=0, return_data=in_data.
REQ-029 Scenario (mid-run reset): rst pulsed high between edges during a stream of back-to-back writes -> outputs 0 at once; outputs resume one edge after release.
REQ-030 Scenario (wide driver): a 32-bit driver of 0x22222222 on rd_in -> rd_out=0x02.
